// File: rtl/router_req_arbiter.sv
// Round-robin arbiter sharing one router transaction engine among N_DEV devices.
// Grants one requester at a time, relays its response, and aborts on cancel or timeout.
module router_req_arbiter #(
  parameter int N_DEV       = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int IDX_W       = $clog2(N_DEV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_DEV-1:0] i_dev_req,
  output logic [N_DEV-1:0] o_dev_grant,
  output logic [N_DEV-1:0] o_dev_resp,
  output logic             o_rtr_req,
  input  logic             i_rtr_resp,
  output logic             o_busy,
  output logic             o_timeout_evt,
  output logic [IDX_W-1:0] o_timeout_dev
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DEV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_RELEASE
  } state_t;

  state_t             r_state, w_state_next;
  logic [IDX_W-1:0]   r_owner, w_owner_next;
  logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_next;
  logic [TMR_W-1:0]   r_timer, w_timer_next;
  logic [N_DEV-1:0]   r_grant, w_grant_next;
  logic [N_DEV-1:0]   r_resp, w_resp_next;
  logic               r_rtr_req, w_rtr_req_next;
  logic               r_busy, w_busy_next;
  logic               r_tevt, w_tevt_next;
  logic [IDX_W-1:0]   r_tdev, w_tdev_next;

  logic               w_any;
  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W-1:0]   w_cand;
  logic [N_DEV-1:0]   w_sel_oh;
  logic [N_DEV-1:0]   w_owner_oh;
  logic               w_owner_req;
  logic               w_done;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_LAST) ? '0 : idx + 1'b1;
  endfunction

  generate
    for (genvar gi = 0; gi < N_DEV; gi++) begin : g_onehot
      assign w_sel_oh[gi]   = (w_sel == IDX_W'(gi));
      assign w_owner_oh[gi] = (r_owner == IDX_W'(gi));
    end
  endgenerate

  assign w_owner_req = |(i_dev_req & w_owner_oh);

  // First asserted request at or after rr_ptr, wrapping modulo N_DEV.
  always_comb begin
    w_any  = 1'b0;
    w_sel  = r_rr_ptr;
    w_cand = r_rr_ptr;
    for (int k = 0; k < N_DEV; k++) begin
      if (!w_any && i_dev_req[w_cand]) begin
        w_any = 1'b1;
        w_sel = w_cand;
      end
      w_cand = wrap_inc(w_cand);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_owner_next   = r_owner;
    w_rr_ptr_next  = r_rr_ptr;
    w_timer_next   = r_timer;
    w_grant_next   = r_grant;
    w_resp_next    = '0;
    w_rtr_req_next = r_rtr_req;
    w_busy_next    = r_busy;
    w_tevt_next    = 1'b0;
    w_tdev_next    = r_tdev;
    w_done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_next   = S_ACTIVE;
          w_owner_next   = w_sel;
          w_grant_next   = w_sel_oh;
          w_rtr_req_next = 1'b1;
          w_busy_next    = 1'b1;
          w_timer_next   = '0;
        end
      end
      S_ACTIVE: begin
        w_timer_next = r_timer + 1'b1;
        // Cancel outranks response, which outranks timeout.
        if (!w_owner_req) begin
          w_done = 1'b1;
        end else if (i_rtr_resp) begin
          w_done      = 1'b1;
          w_resp_next = w_owner_oh;
        end else if (r_timer == TMR_LAST) begin
          w_done      = 1'b1;
          w_tevt_next = 1'b1;
          w_tdev_next = r_owner;
        end
        if (w_done) begin
          w_state_next   = S_RELEASE;
          w_grant_next   = '0;
          w_rtr_req_next = 1'b0;
        end
      end
      S_RELEASE: begin
        w_state_next  = S_IDLE;
        w_rr_ptr_next = wrap_inc(r_owner);
        w_busy_next   = 1'b0;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_timer   <= '0;
      r_grant   <= '0;
      r_resp    <= '0;
      r_rtr_req <= 1'b0;
      r_busy    <= 1'b0;
      r_tevt    <= 1'b0;
      r_tdev    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_owner   <= w_owner_next;
      r_rr_ptr  <= w_rr_ptr_next;
      r_timer   <= w_timer_next;
      r_grant   <= w_grant_next;
      r_resp    <= w_resp_next;
      r_rtr_req <= w_rtr_req_next;
      r_busy    <= w_busy_next;
      r_tevt    <= w_tevt_next;
      r_tdev    <= w_tdev_next;
    end
  end

  assign o_dev_grant   = r_grant;
  assign o_dev_resp    = r_resp;
  assign o_rtr_req     = r_rtr_req;
  assign o_busy        = r_busy;
  assign o_timeout_evt = r_tevt;
  assign o_timeout_dev = r_tdev;

endmodule

// File: tb/tb_router_req_arbiter.sv
// Scoreboard bench for router_req_arbiter: directed stimulus pushes expected events,
// a negedge monitor pops and compares each grant, response, timeout and release it sees.
module tb_router_req_arbiter;

  localparam int N_DEV = 4;
  localparam int TOUT  = 8;
  localparam int IDX_W = 2;

  localparam int K_GRANT = 0;
  localparam int K_RESP  = 1;
  localparam int K_TOUT  = 2;
  localparam int K_DROP  = 3;

  logic             clk;
  logic             reset;
  logic [N_DEV-1:0] dev_req;
  logic [N_DEV-1:0] dev_grant;
  logic [N_DEV-1:0] dev_resp;
  logic             rtr_req;
  logic             rtr_resp;
  logic             busy;
  logic             timeout_evt;
  logic [IDX_W-1:0] timeout_dev;

  router_req_arbiter #(
    .N_DEV(N_DEV),
    .TIMEOUT_CYC(TOUT),
    .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_dev_req(dev_req),
    .o_dev_grant(dev_grant),
    .o_dev_resp(dev_resp),
    .o_rtr_req(rtr_req),
    .i_rtr_resp(rtr_resp),
    .o_busy(busy),
    .o_timeout_evt(timeout_evt),
    .o_timeout_dev(timeout_dev)
  );

  typedef struct {
    int         kind;
    logic [3:0] vec;
    int         cyc;
  } ev_t;

  // Snapshot packing: {busy, rtr_req, grant[3:0], resp[3:0], timeout_evt, timeout_dev[1:0]}
  typedef struct {
    int          cyc;
    logic [12:0] val;
  } snap_t;

  ev_t   ev_q[$];
  snap_t snap_q[$];

  int   cyc = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  logic mon_en = 1'b0;
  logic done = 1'b0;
  logic [N_DEV-1:0] prev_grant = '0;
  logic             prev_rtr = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int kind);
    case (kind)
      K_GRANT: return "grant";
      K_RESP:  return "resp";
      K_TOUT:  return "timeout";
      default: return "release";
    endcase
  endfunction

  // ---------------- monitor / checker ----------------
  task automatic observe(input int kind, input logic [3:0] vec);
    ev_t e;
    chk_cnt++;
    if (ev_q.size() == 0) begin
      $display("FAIL unexpected_%s: got vec=%b at cycle %0d, expected no event", kname(kind), vec, cyc);
    end else begin
      e = ev_q.pop_front();
      if (e.kind == kind && e.vec == vec && e.cyc == cyc) begin
        pass_cnt++;
        $display("ok   %s vec=%b cycle %0d", kname(kind), vec, cyc);
      end else begin
        $display("FAIL event_%s: got %s vec=%b cycle %0d, expected %s vec=%b cycle %0d",
                 kname(e.kind), kname(kind), vec, cyc, kname(e.kind), e.vec, e.cyc);
      end
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check_bit("inv_grant_onehot0", $onehot0(dev_grant), 1'b1);
      check_bit("inv_rtr_req_eq_or_grant", rtr_req, |dev_grant);
      check_bit("inv_resp_subset_prev_grant", |(dev_resp & ~prev_grant), 1'b0);

      if (dev_grant != '0 && dev_grant != prev_grant) observe(K_GRANT, dev_grant);
      if (dev_resp != '0) observe(K_RESP, dev_resp);
      if (timeout_evt) observe(K_TOUT, 4'(timeout_dev));
      if (prev_rtr && !rtr_req) observe(K_DROP, 4'b0000);

      while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
        snap_t s;
        logic [12:0] act;
        s = snap_q.pop_front();
        act = {busy, rtr_req, dev_grant, dev_resp, timeout_evt, timeout_dev};
        chk_cnt++;
        if (s.cyc == cyc && act === s.val) begin
          pass_cnt++;
          $display("ok   snapshot cycle %0d outputs=%b", cyc, act);
        end else begin
          $display("FAIL snapshot_c%0d: got outputs=%b at cycle %0d expected %b", s.cyc, act, cyc, s.val);
        end
      end

      prev_grant <= dev_grant;
      prev_rtr   <= rtr_req;

      if (done) begin
        chk_cnt++;
        if (ev_q.size() == 0) pass_cnt++;
        else $display("FAIL events_drained: got %0d pending expected 0 (next %s at cycle %0d)",
                      ev_q.size(), kname(ev_q[0].kind), ev_q[0].cyc);
        chk_cnt++;
        if (snap_q.size() == 0) pass_cnt++;
        else $display("FAIL snapshots_drained: got %0d pending expected 0", snap_q.size());
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ev(input int kind, input logic [3:0] vec, input int at);
    ev_t e;
    e.kind = kind;
    e.vec  = vec;
    e.cyc  = at;
    ev_q.push_back(e);
  endtask

  task automatic snap(input int at, input logic b, input logic r, input logic [3:0] g,
                      input logic [3:0] rs, input logic te, input logic [1:0] td);
    snap_t s;
    s.cyc = at;
    s.val = {b, r, g, rs, te, td};
    snap_q.push_back(s);
  endtask

  int g;
  int g2;

  initial begin
    reset    = 1'b1;
    dev_req  = '0;
    rtr_resp = 1'b0;
    tick(1);
    mon_en = 1'b1;
    snap(cyc, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

    // Single request from device 2, response 4 cycles after the grant.
    dev_req = 4'b0100;
    ev(K_GRANT, 4'b0100, cyc + 1);
    snap(cyc + 1, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 2'd0);
    tick(5);
    rtr_resp = 1'b1;
    ev(K_RESP, 4'b0100, cyc + 1);
    ev(K_DROP, 4'b0000, cyc + 1);
    snap(cyc + 1, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b0, 2'd0);
    snap(cyc + 2, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);
    tick(1);
    rtr_resp = 1'b0;
    dev_req  = '0;
    tick(2);

    // rr_ptr is now 3: with devices 0 and 3 pending, 3 wins, then 0.
    dev_req = 4'b1001;
    ev(K_GRANT, 4'b1000, cyc + 1);
    tick(1);
    rtr_resp = 1'b1;
    ev(K_RESP, 4'b1000, cyc + 1);
    ev(K_DROP, 4'b0000, cyc + 1);
    tick(1);
    rtr_resp = 1'b0;
    dev_req  = 4'b0001;
    ev(K_GRANT, 4'b0001, cyc + 2);
    tick(2);
    rtr_resp = 1'b1;
    ev(K_RESP, 4'b0001, cyc + 1);
    ev(K_DROP, 4'b0000, cyc + 1);
    tick(1);
    rtr_resp = 1'b0;
    dev_req  = '0;
    tick(2);

    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    snap(cyc, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);
    tick(1);

    // Round robin with everyone requesting: order 0,1,2,3,0, two low cycles between grants.
    dev_req = 4'b1111;
    g = cyc + 1;
    ev(K_GRANT, 4'b0001, g);
    for (int k = 0; k < 5; k++) begin
      tick(g + 1 - cyc);
      rtr_resp = 1'b1;
      ev(K_RESP, 4'(1 << (k % 4)), g + 2);
      ev(K_DROP, 4'b0000, g + 2);
      if (k < 4) ev(K_GRANT, 4'(1 << ((k + 1) % 4)), g + 4);
      tick(1);
      rtr_resp = 1'b0;
      g = g + 4;
    end
    dev_req = '0;
    tick(2);

    // Cancel by device 1 coincident with rtr_resp: no response, release next cycle.
    dev_req = 4'b0010;
    ev(K_GRANT, 4'b0010, cyc + 1);
    tick(4);
    dev_req  = 4'b0000;
    rtr_resp = 1'b1;
    ev(K_DROP, 4'b0000, cyc + 1);
    snap(cyc + 1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);
    tick(1);
    rtr_resp = 1'b0;

    // rr_ptr=2: device 2 wins among {0,2,3}, then times out 8 cycles after its grant.
    dev_req = 4'b1101;
    g = cyc + 2;
    ev(K_GRANT, 4'b0100, g);
    ev(K_TOUT, 4'b0010, g + TOUT);
    ev(K_DROP, 4'b0000, g + TOUT);
    snap(g + TOUT, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2);
    tick(g + TOUT - cyc);
    dev_req = 4'b1000;

    // Device 3 next; its response lands on the last timer cycle and wins over timeout.
    g2 = cyc + 2;
    ev(K_GRANT, 4'b1000, g2);
    tick(g2 + TOUT - 1 - cyc);
    rtr_resp = 1'b1;
    ev(K_RESP, 4'b1000, g2 + TOUT);
    ev(K_DROP, 4'b0000, g2 + TOUT);
    tick(1);
    rtr_resp = 1'b0;
    dev_req  = '0;
    tick(2);

    // Move rr_ptr to 2, then reset in the middle of device 2's transaction.
    dev_req = 4'b0010;
    ev(K_GRANT, 4'b0010, cyc + 1);
    tick(2);
    rtr_resp = 1'b1;
    ev(K_RESP, 4'b0010, cyc + 1);
    ev(K_DROP, 4'b0000, cyc + 1);
    tick(1);
    rtr_resp = 1'b0;
    dev_req  = 4'b1110;
    ev(K_GRANT, 4'b0100, cyc + 2);
    tick(3);
    dev_req = 4'b1111;
    reset   = 1'b1;
    ev(K_DROP, 4'b0000, cyc + 1);
    snap(cyc + 1, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0);
    tick(1);
    reset = 1'b0;
    ev(K_GRANT, 4'b0001, cyc + 1);
    tick(2);
    rtr_resp = 1'b1;
    ev(K_RESP, 4'b0001, cyc + 1);
    ev(K_DROP, 4'b0000, cyc + 1);
    tick(1);
    rtr_resp = 1'b0;
    dev_req  = '0;
    tick(4);

    done = 1'b1;
  end

endmodule
